// File: rtl/neuron_layer_driver.sv
// Buffers one input vector, broadcasts it to a bank of neurons, collects each
// neuron's first result, and streams the results out in index order.
module neuron_layer_driver #(
  parameter int INPUT_SIZE  = 784,
  parameter int NUM_NEURONS = 10,
  parameter int TIMEOUT     = 1023
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic [15:0]                    in_data,
  output logic                           in_ready,
  output logic [16*INPUT_SIZE-1:0]       vec_out,
  output logic                           nrn_start,
  input  logic [NUM_NEURONS-1:0]         nrn_done,
  input  logic [16*NUM_NEURONS-1:0]      nrn_result,
  output logic                           out_valid,
  output logic [15:0]                    out_data,
  output logic [$clog2(NUM_NEURONS)-1:0] out_idx,
  output logic                           out_last,
  input  logic                           out_ready,
  output logic                           err_timeout
);

  localparam int DATA_W = 16;
  localparam int WCNT_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int IDX_W  = $clog2(NUM_NEURONS);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(INPUT_SIZE - 1);
  localparam logic [IDX_W-1:0]  RIDX_LAST = IDX_W'(NUM_NEURONS - 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(TIMEOUT);

  typedef enum logic [1:0] {LOAD, FIRE, WAIT, DRAIN} state_t;

  state_t                             state, state_nxt;
  logic [WCNT_W-1:0]                  wcnt;
  logic [IDX_W-1:0]                   ridx;
  logic [TCNT_W-1:0]                  tcnt, tcnt_inc;
  logic [NUM_NEURONS-1:0]             flag, cap_en, flag_nxt;
  logic                               all_done, timeout_hit;
  logic                               in_acc, out_hs, wcnt_last, ridx_last;
  logic [INPUT_SIZE-1:0][DATA_W-1:0]  vec_q;
  logic signed [DATA_W-1:0]           res_q [NUM_NEURONS];

  assign in_acc    = (state == LOAD) && in_valid && in_ready;
  assign out_hs    = (state == DRAIN) && out_ready;
  assign wcnt_last = (wcnt == WCNT_LAST);
  assign ridx_last = (ridx == RIDX_LAST);

  // Only WAIT listens to the neurons; a flag blocks any later pulse from
  // overwriting the first captured result.
  assign cap_en      = (state == WAIT) ? (nrn_done & ~flag) : '0;
  assign flag_nxt    = flag | cap_en;
  assign all_done    = &flag_nxt;
  assign tcnt_inc    = tcnt + 1'b1;
  assign timeout_hit = (state == WAIT) && !all_done && (tcnt_inc == TCNT_MAX);

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_acc && wcnt_last) state_nxt = FIRE;
      FIRE:    state_nxt = WAIT;
      WAIT:    if (all_done || timeout_hit) state_nxt = DRAIN;
      DRAIN:   if (out_hs && ridx_last) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Control: in_ready is registered so it stays low through reset and rises
  // on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      in_ready    <= 1'b0;
      wcnt        <= '0;
      ridx        <= '0;
      tcnt        <= '0;
      flag        <= '0;
      err_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == LOAD);
      if (in_acc) wcnt <= wcnt_last ? '0 : wcnt + 1'b1;
      if (out_hs) ridx <= ridx_last ? '0 : ridx + 1'b1;
      if (state == FIRE) begin
        flag <= '0;
        tcnt <= '0;
      end else if (state == WAIT) begin
        flag <= flag_nxt;
        tcnt <= tcnt_inc;
        if (timeout_hit) err_timeout <= 1'b1;
      end
    end
  end

  // Input vector buffer, written only while loading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vec_q <= '0;
    else if (in_acc) vec_q[wcnt] <= in_data;
  end

  // Result capture; cleared on FIRE so a timed-out neuron reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) res_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (state == FIRE) res_q[i] <= '0;
        else if (cap_en[i]) res_q[i] <= nrn_result[i*DATA_W +: DATA_W];
      end
    end
  end

  assign vec_out   = vec_q;
  assign nrn_start = (state == FIRE);
  assign out_valid = (state == DRAIN);
  assign out_data  = res_q[ridx];
  assign out_idx   = ridx;
  assign out_last  = (state == DRAIN) && ridx_last;

endmodule

// File: tb/tb_neuron_layer_driver.sv
// Bench for neuron_layer_driver: scripted neuron responders, a result-order
// model checked every cycle, and literal spot checks per scenario.
module tb_neuron_layer_driver;
  localparam int N   = 784;
  localparam int NN  = 10;
  localparam int TO  = 1023;
  localparam int IW  = $clog2(NN);
  localparam int INF = 32'h7fffffff;

  logic                 clk, rst_n, in_valid, in_ready, nrn_start;
  logic [15:0]          in_data, out_data;
  logic [16*N-1:0]      vec_out;
  logic [NN-1:0]        nrn_done;
  logic [16*NN-1:0]     nrn_result;
  logic                 out_valid, out_last, out_ready, err_timeout;
  logic [IW-1:0]        out_idx;

  neuron_layer_driver #(.INPUT_SIZE(N), .NUM_NEURONS(NN), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .vec_out(vec_out), .nrn_start(nrn_start),
    .nrn_done(nrn_done), .nrn_result(nrn_result), .out_valid(out_valid),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .out_ready(out_ready), .err_timeout(err_timeout));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [63:0] got_v, input logic [63:0] exp_v);
    tests++;
    if (got_v !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got_v, exp_v);
    end
  endtask

  // Neuron schedule: pulse j of neuron i comes p_off cycles after the start cycle.
  int          p_off [NN][4];
  logic [15:0] p_val [NN][4];
  int          p_cnt [NN];

  task automatic clear_sched();
    for (int i = 0; i < NN; i++) p_cnt[i] = 0;
  endtask

  task automatic add_pulse(input int i, input int off, input logic [15:0] v);
    p_off[i][p_cnt[i]] = off;
    p_val[i][p_cnt[i]] = v;
    p_cnt[i]++;
  endtask

  // Model state
  typedef struct { logic [15:0] d; int idx; bit last; } beat_t;
  beat_t       q[$];
  logic [15:0] mvec [N];
  logic [15:0] got [NN];
  int          mi = 0, acc_last = -10, cyc = 0, drain_cyc = INF, nbeats = 0;
  bit          full = 0, busy = 0, vt = 0, err_sticky = 0;
  bit          rdy_rand = 0;
  logic        edge_seen;

  // Each neuron keeps its first pulse inside the wait window; the window closes
  // when the slowest neuron answers, or after TO cycles if any never does.
  task automatic model_vector(output bit tmo, output int endo);
    int first [NN];
    logic [15:0] fv [NN];
    int mx;
    beat_t b;
    mx = 0;
    tmo = 0;
    for (int i = 0; i < NN; i++) begin
      first[i] = -1;
      fv[i] = '0;
      for (int j = 0; j < p_cnt[i]; j++)
        if (p_off[i][j] >= 1 && (first[i] < 0 || p_off[i][j] < first[i])) begin
          first[i] = p_off[i][j];
          fv[i] = p_val[i][j];
        end
      if (first[i] < 0 || first[i] > TO) tmo = 1;
      else if (first[i] > mx) mx = first[i];
    end
    endo = tmo ? TO : mx;
    for (int i = 0; i < NN; i++) begin
      b.d = (first[i] >= 1 && first[i] <= endo) ? fv[i] : 16'h0000;
      b.idx = i;
      b.last = (i == NN - 1);
      q.push_back(b);
    end
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) edge_seen <= 1'b0;
    else edge_seen <= 1'b1;

  // Neuron responder
  initial begin
    int mx;
    nrn_done = '0;
    nrn_result = '0;
    forever begin
      @(negedge clk);
      if (rst_n && nrn_start) begin
        mx = 0;
        for (int i = 0; i < NN; i++)
          for (int j = 0; j < p_cnt[i]; j++)
            if (p_off[i][j] > mx) mx = p_off[i][j];
        for (int k = 1; k <= mx; k++) begin
          @(posedge clk); #1;
          nrn_done = '0;
          if (!rst_n) break;
          for (int i = 0; i < NN; i++)
            for (int j = 0; j < p_cnt[i]; j++)
              if (p_off[i][j] == k) begin
                nrn_done[i] = 1'b1;
                nrn_result[i*16 +: 16] = p_val[i][j];
              end
        end
        @(posedge clk); #1;
        nrn_done = '0;
      end
    end
  end

  // Downstream ready
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    bit exp_start, exp_ov, tmo;
    int e, bad;
    cyc++;
    if (!rst_n) begin
      check("rst_outputs", {nrn_start, out_valid, out_last, err_timeout, in_ready, out_idx, out_data}, '0);
      check("rst_vec_out_zero", 64'(vec_out == '0), 1);
      mi = 0; full = 0; busy = 0; vt = 0; err_sticky = 0;
      drain_cyc = INF; acc_last = -10;
      q.delete();
    end else begin
      check("in_ready", in_ready, edge_seen && !busy);
      exp_start = full && (cyc == acc_last + 1);
      check("nrn_start", nrn_start, exp_start);
      if (nrn_start && exp_start) begin
        bad = -1;
        for (int k = 0; k < N; k++)
          if (bad < 0 && vec_out[k*16 +: 16] !== mvec[k]) bad = k;
        check("vec_out_matches_stream", 64'(bad < 0), 1);
        full = 0;
        mi = 0;
        model_vector(tmo, e);
        vt = tmo;
        drain_cyc = cyc + e + 1;
      end
      if (cyc == drain_cyc && vt) err_sticky = 1;
      check("err_timeout", err_timeout, err_sticky);
      exp_ov = busy && (cyc >= drain_cyc) && (q.size() > 0);
      check("out_valid", out_valid, exp_ov);
      if (out_valid && q.size() > 0) begin
        check("out_data", out_data, q[0].d);
        check("out_idx", out_idx, q[0].idx);
        check("out_last", out_last, q[0].last);
        got[out_idx] = out_data;
        if (out_ready) begin
          if (q[0].last) begin
            busy = 0;
            drain_cyc = INF;
          end
          void'(q.pop_front());
          nbeats++;
        end
      end
      if (in_valid && in_ready) begin
        if (mi < N) mvec[mi] = in_data;
        mi++;
        acc_last = cyc;
        if (mi == N) begin
          full = 1;
          busy = 1;
        end
      end
    end
  end

  task automatic send_words(input int cnt, input int mul, input int add, input bit rnd);
    int k, guard;
    bit acc;
    k = 0;
    guard = 0;
    while (k < cnt) begin
      in_data = 16'(k * mul + add);
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) k++;
      guard++;
      if (guard > 20000) begin
        check("send_budget", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((busy || q.size() > 0) && g < 5000) begin
      @(posedge clk);
      g++;
    end
    if (g >= 5000) check("idle_budget", 0, 1);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    clear_sched();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // A: word k = k, every neuron answers one cycle after start
    for (int i = 0; i < NN; i++) add_pulse(i, 1, 16'h0100 + 16'(i));
    nb = nbeats;
    send_words(N, 1, 0, 0);
    wait_idle();
    check("A_vec0", vec_out[0 +: 16], 16'd0);
    check("A_vec783", vec_out[783*16 +: 16], 16'd783);
    check("A_got0", got[0], 16'h0100);
    check("A_got9", got[9], 16'h0109);
    check("A_beats", nbeats - nb, 10);
    check("A_err", err_timeout, 0);

    // B: neuron 3 at cycle 2, rest at 5, neuron 3 again at 6 (in DRAIN)
    clear_sched();
    for (int i = 0; i < NN; i++) if (i != 3) add_pulse(i, 5, 16'h0200 + 16'(i));
    add_pulse(3, 2, 16'h0AA3);
    add_pulse(3, 6, 16'h0BB3);
    send_words(N, 2, 1, 0);
    wait_idle();
    check("B_got3_first_kept", got[3], 16'h0AA3);
    check("B_got4", got[4], 16'h0204);

    // B2: repeat pulse from neuron 3 inside the wait window
    clear_sched();
    for (int i = 0; i < NN; i++) if (i != 3) add_pulse(i, 5, 16'h0300 + 16'(i));
    add_pulse(3, 2, 16'h0CC3);
    add_pulse(3, 4, 16'h0DD3);
    send_words(N, 1, 100, 0);
    wait_idle();
    check("B2_got3_first_kept", got[3], 16'h0CC3);
    check("B2_got9", got[9], 16'h0309);

    // C: neuron 7 silent -> timeout, negative results pass unchanged
    clear_sched();
    for (int i = 0; i < NN; i++) if (i != 7) add_pulse(i, 1, 16'hF000 + 16'(i));
    send_words(N, 1, 5, 0);
    wait_idle();
    check("C_err_set", err_timeout, 1);
    check("C_got7_zero", got[7], 16'h0000);
    check("C_got6", got[6], 16'hF006);
    check("C_got8", got[8], 16'hF008);

    // D: random valid/ready and random neuron latencies; err stays sticky
    clear_sched();
    for (int i = 0; i < NN; i++) add_pulse(i, $urandom_range(1, 8), 16'($urandom));
    rdy_rand = 1;
    nb = nbeats;
    send_words(N, 5, 3, 1);
    wait_idle();
    rdy_rand = 0;
    check("D_beats", nbeats - nb, 10);
    check("D_err_sticky", err_timeout, 1);

    // E: reset in the middle of LOAD, then a fresh vector from index 0
    send_words(100, 1, 1000, 0);
    rst_n = 1'b0;
    #1 check("E_rst_in_ready", in_ready, 0);
    check("E_rst_err", err_timeout, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_sched();
    for (int i = 0; i < NN; i++) add_pulse(i, 1, 16'h0400 + 16'(i));
    send_words(N, 1, 7, 0);
    wait_idle();
    check("E_vec0", vec_out[0 +: 16], 16'd7);
    check("E_vec1", vec_out[16 +: 16], 16'd8);
    check("E_got5", got[5], 16'h0405);

    // F: reset in the middle of WAIT
    clear_sched();
    add_pulse(0, 50, 16'h1111);
    for (int i = 1; i < NN; i++) add_pulse(i, 1, 16'h2220 + 16'(i));
    send_words(N, 1, 0, 0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("F_rst_outs", {nrn_start, out_valid, out_last, in_ready, err_timeout, out_data}, '0);
    check("F_rst_vec0", vec_out[783*16 +: 16], 16'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_sched();
    for (int i = 0; i < NN; i++) add_pulse(i, 2, 16'h0500 + 16'(i));
    send_words(N, 1, 11, 0);
    wait_idle();
    check("F_got0", got[0], 16'h0500);
    check("F_got9", got[9], 16'h0509);
    check("F_vec783", vec_out[783*16 +: 16], 16'd794);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
